// File: rtl/dm_wait_ctrl_if.sv
// D-interface between the memory stage (master) and the data memory (slave).
interface dm_wait_ctrl_if;
  logic [31:0] DPC;
  logic [31:0] DAddr;
  logic        DREn;
  logic        DWEn;
  logic [3:0]  DByteEn;
  logic [31:0] DWData;
  logic [31:0] DRData;
  logic        DReady;

  modport master (
    output DPC, DAddr, DREn, DWEn, DByteEn, DWData,
    input  DRData, DReady
  );

  modport slave (
    input  DPC, DAddr, DREn, DWEn, DByteEn, DWData,
    output DRData, DReady
  );
endinterface

// File: rtl/dm_wait_ctrl.sv
// Data memory behind the memory stage: word RAM with a programmable number of
// wait cycles, exactly-once byte-enable writes and an optional clear-on-reset.
// Optional write log: define DM_WRITE_LOG_EN to print every committed write.
module dm_wait_ctrl #(
  parameter int unsigned WORDS     = 4096,
  parameter int unsigned LATENCY   = 2,
  parameter int unsigned INIT_ZERO = 1
) (
  input  logic          clk,
  input  logic          reset,
  dm_wait_ctrl_if.slave d,
  output logic          initBusy
);

  localparam int unsigned AW = (WORDS > 1) ? $clog2(WORDS) : 1;
  localparam int unsigned CW = 4;
  localparam int unsigned KW = 65;
  localparam logic [CW-1:0] CNT_START = (LATENCY == 0) ? '0 : CW'(LATENCY - 1);

  typedef enum logic [1:0] {S_INIT, S_IDLE, S_WAIT, S_DONE} state_t;

  logic [31:0]   mem [WORDS];
  state_t        state;
  logic [CW-1:0] cnt;
  logic [AW-1:0] init_idx;
  logic [KW-1:0] key_q;
  logic          dready_q;
  logic [31:0]   drdata_q;
  logic          init_busy_q;

  logic          req_c;
  logic          same_key_c;
  logic          accept_c;
  logic          commit_c;
  logic          ram_we_c;
  logic [KW-1:0] key_c;
  logic [AW-1:0] idx_c;
  logic [AW-1:0] ram_idx_c;
  logic [31:0]   rd_word_c;
  logic [31:0]   merged_c;
  logic [31:0]   ram_wdata_c;

  // Request decode, byte merge and RAM write-port steering.
  always_comb begin
    req_c      = d.DREn | d.DWEn;
    key_c      = {d.DPC, d.DAddr, d.DWEn};
    same_key_c = req_c && (key_c == key_q);
    idx_c      = d.DAddr[AW+1:2];
    rd_word_c  = mem[idx_c];
    merged_c   = rd_word_c;
    for (int i = 0; i < 4; i++) begin
      if (d.DByteEn[i]) merged_c[8*i +: 8] = d.DWData[8*i +: 8];
    end
    // A new key in WAIT/DONE restarts exactly as a fresh request from IDLE.
    accept_c = req_c && ((state == S_IDLE) ||
               (((state == S_WAIT) || (state == S_DONE)) && !same_key_c));
    if (LATENCY == 0) commit_c = accept_c;
    else              commit_c = (state == S_WAIT) && same_key_c && (cnt == '0);
    ram_we_c    = 1'b0;
    ram_idx_c   = idx_c;
    ram_wdata_c = merged_c;
    if (!reset) begin
      if (state == S_INIT) begin
        ram_we_c    = 1'b1;
        ram_idx_c   = init_idx;
        ram_wdata_c = '0;
      end else if (commit_c && d.DWEn) begin
        ram_we_c = 1'b1;
      end
    end
  end

  // Single RAM write port shared by the reset clear and request commits.
  always_ff @(posedge clk) begin
    if (ram_we_c) mem[ram_idx_c] <= ram_wdata_c;
  end

`ifdef DM_WRITE_LOG_EN
  // Trace each committed write; live key equals the latched key at commit.
  always_ff @(posedge clk) begin
    if (!reset && commit_c && d.DWEn)
      $display("%d@%h: *%h <= %h", $time, d.DPC, d.DAddr, merged_c);
  end
`endif

  // Control FSM: clear, accept, count wait cycles, hold completion while frozen.
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= (INIT_ZERO != 0) ? S_INIT : S_IDLE;
      init_busy_q <= (INIT_ZERO != 0);
      init_idx    <= '0;
      cnt         <= '0;
      key_q       <= '0;
      dready_q    <= 1'b0;
      drdata_q    <= '0;
    end else begin
      case (state)
        S_INIT: begin
          init_idx <= init_idx + AW'(1);
          if (init_idx == AW'(WORDS - 1)) begin
            state       <= S_IDLE;
            init_busy_q <= 1'b0;
          end
        end
        default: begin
          if (accept_c) begin
            key_q <= key_c;
            if (LATENCY == 0) begin
              state    <= S_DONE;
              dready_q <= 1'b1;
              drdata_q <= rd_word_c;
            end else begin
              state    <= S_WAIT;
              cnt      <= CNT_START;
              dready_q <= 1'b0;
            end
          end else if (state == S_WAIT) begin
            if (!req_c) begin
              state <= S_IDLE;
            end else if (cnt == '0) begin
              state    <= S_DONE;
              dready_q <= 1'b1;
              drdata_q <= rd_word_c;
            end else begin
              cnt <= cnt - CW'(1);
            end
          end else if ((state == S_DONE) && !req_c) begin
            state    <= S_IDLE;
            dready_q <= 1'b0;
          end
        end
      endcase
    end
  end

  // Zero latency answers in the accept cycle; otherwise ready is the DONE flag,
  // masked while a new request is being taken so the stage cannot skip it.
  if (LATENCY == 0) begin : g_lat0
    assign d.DReady = accept_c | (state == S_DONE);
    assign d.DRData = accept_c ? rd_word_c : drdata_q;
  end else begin : g_latn
    assign d.DReady = dready_q & ~accept_c;
    assign d.DRData = drdata_q;
  end

  assign initBusy = init_busy_q;

endmodule

// File: tb/tb_dm_wait_ctrl.sv
// Bench for dm_wait_ctrl: a LATENCY=2 instance and a LATENCY=0 instance.
module tb_dm_wait_ctrl;
  localparam int unsigned WORDS  = 64;
  localparam int unsigned LAT    = 2;
  localparam int unsigned WORDS0 = 32;

  logic clk = 1'b0;
  logic reset;
  logic init_busy;
  logic init_busy0;

  always #5 clk = ~clk;

  dm_wait_ctrl_if bus ();
  dm_wait_ctrl_if bus0 ();

  dm_wait_ctrl #(.WORDS(WORDS), .LATENCY(LAT), .INIT_ZERO(1)) u_dut (
    .clk(clk), .reset(reset), .d(bus), .initBusy(init_busy)
  );

  dm_wait_ctrl #(.WORDS(WORDS0), .LATENCY(0), .INIT_ZERO(1)) u_dut0 (
    .clk(clk), .reset(reset), .d(bus0), .initBusy(init_busy0)
  );

  typedef struct {
    bit          wr;
    logic [31:0] addr;
    logic [3:0]  be;
    logic [31:0] wd;
    logic [31:0] exp_rd;
  } vec_t;

  int unsigned vectors = 0;
  int unsigned errors  = 0;
  logic [31:0] mdl [WORDS];
  logic [31:0] pc  = 32'h0040_0000;
  logic [31:0] pc0 = 32'h0080_0000;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic present(input bit wr, input logic [31:0] addr, input logic [3:0] be,
                         input logic [31:0] wd);
    bus.DPC = pc; bus.DAddr = addr; bus.DREn = !wr; bus.DWEn = wr;
    bus.DByteEn = be; bus.DWData = wd;
  endtask

  task automatic idle();
    bus.DREn = 1'b0; bus.DWEn = 1'b0;
  endtask

  task automatic present0(input bit wr, input logic [31:0] addr, input logic [3:0] be,
                          input logic [31:0] wd);
    pc0 += 32'd4;
    bus0.DPC = pc0; bus0.DAddr = addr; bus0.DREn = !wr; bus0.DWEn = wr;
    bus0.DByteEn = be; bus0.DWData = wd;
  endtask

  function automatic int unsigned widx(input logic [31:0] a);
    return (a >> 2) % WORDS;
  endfunction

  function automatic void merge(input logic [31:0] addr, input logic [3:0] be,
                                input logic [31:0] wd);
    int unsigned w = widx(addr);
    for (int i = 0; i < 4; i++) if (be[i]) mdl[w][8*i +: 8] = wd[8*i +: 8];
  endfunction

  // One complete request on the LATENCY=2 port: ready must come LAT+1 cycles
  // after the request first appears; the request is left driven afterwards.
  task automatic do_txn(input bit wr, input logic [31:0] addr, input logic [3:0] be,
                        input logic [31:0] wd, input logic [31:0] exp_rd, input string name);
    int unsigned age = 0;
    bit got = 1'b0;
    pc += 32'd4;
    present(wr, addr, be, wd);
    while (!got && age <= LAT + 8) begin
      @(negedge clk);
      if (bus.DReady === 1'b1) got = 1'b1;
      else begin tick(); age++; end
    end
    check({name, "_lat"}, age, LAT + 1);
    if (got) begin
      if (wr) merge(addr, be, wd);
      else    check({name, "_data"}, bus.DRData, exp_rd);
      tick();
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t tbl [12];
    int unsigned n_busy = 0;
    int unsigned n_busy0 = 0;

    tbl[0]  = '{1'b1, 32'h10,  4'b1111, 32'h1234_5678, 32'h0};
    tbl[1]  = '{1'b0, 32'h10,  4'b0000, 32'h0,         32'h1234_5678};
    tbl[2]  = '{1'b1, 32'h10,  4'b0100, 32'h00AB_0000, 32'h0};
    tbl[3]  = '{1'b0, 32'h10,  4'b0000, 32'h0,         32'h12AB_5678};
    tbl[4]  = '{1'b0, 32'h20,  4'b0000, 32'h0,         32'h0};
    tbl[5]  = '{1'b1, 32'h24,  4'b0000, 32'hDEAD_BEEF, 32'h0};
    tbl[6]  = '{1'b0, 32'h24,  4'b0000, 32'h0,         32'h0};
    tbl[7]  = '{1'b1, 32'h24,  4'b1001, 32'hAA00_00BB, 32'h0};
    tbl[8]  = '{1'b0, 32'h24,  4'b0000, 32'h0,         32'hAA00_00BB};
    tbl[9]  = '{1'b1, 32'h124, 4'b0010, 32'h0000_CC00, 32'h0};
    tbl[10] = '{1'b0, 32'h24,  4'b0000, 32'h0,         32'hAA00_CCBB};
    tbl[11] = '{1'b0, 32'hFC,  4'b0000, 32'h0,         32'h0};

    for (int i = 0; i < int'(WORDS); i++) mdl[i] = 32'h0;
    bus.DPC = '0; bus.DAddr = '0; bus.DREn = 1'b0; bus.DWEn = 1'b0;
    bus.DByteEn = '0; bus.DWData = '0;
    bus0.DPC = '0; bus0.DAddr = '0; bus0.DREn = 1'b0; bus0.DWEn = 1'b0;
    bus0.DByteEn = '0; bus0.DWData = '0;

    // Reset values.
    reset = 1'b1;
    tick();
    @(negedge clk);
    check("rst_ready", bus.DReady, 1'b0);
    check("rst_rdata", bus.DRData, 32'h0);
    check("rst_init_busy", init_busy, 1'b1);
    check("rst_init_busy0", init_busy0, 1'b1);
    tick();
    reset = 1'b0;

    // Clear phase length; requests during the clear are ignored.
    for (int c = 0; c < 300; c++) begin
      if (c < 10) present(1'b1, 32'h0, 4'hF, 32'hFFFF_FFFF);
      else        idle();
      @(negedge clk);
      if (c < 10) check("init_ignore", bus.DReady, 1'b0);
      if (init_busy0) n_busy0++;
      if (!init_busy) begin tick(); break; end
      n_busy++;
      tick();
    end
    check("init_cycles", n_busy, WORDS);
    check("init_cycles0", n_busy0, WORDS0);

    // Directed transaction table.
    for (int i = 0; i < 12; i++) begin
      do_txn(tbl[i].wr, tbl[i].addr, tbl[i].be, tbl[i].wd, tbl[i].exp_rd, "table");
      idle();
      tick();
    end

    // Frozen pipeline: identical write held in DONE while data changes.
    do_txn(1'b1, 32'h30, 4'hF, 32'h1122_3344, 32'h0, "freeze_wr");
    for (int a = 0; a < 5; a++) begin
      bus.DWData = 32'hFFFF_FFFF;
      @(negedge clk);
      check("freeze_ready", bus.DReady, 1'b1);
      tick();
    end
    idle();
    tick();
    do_txn(1'b0, 32'h30, 4'h0, 32'h0, 32'h1122_3344, "freeze_rd");
    idle();
    tick();

    // Abort by dropping the request while still waiting.
    pc += 32'd4;
    present(1'b1, 32'h20, 4'hF, 32'hCAFE_F00D);
    for (int a = 0; a < 2; a++) begin
      @(negedge clk); check("abort_ready", bus.DReady, 1'b0); tick();
    end
    idle();
    for (int a = 0; a < 3; a++) begin
      @(negedge clk); check("abort_idle_ready", bus.DReady, 1'b0); tick();
    end
    do_txn(1'b0, 32'h20, 4'h0, 32'h0, 32'h0, "abort_rd");
    idle();
    tick();

    // Abort by key change while waiting: the new request restarts cleanly.
    pc += 32'd4;
    present(1'b1, 32'h28, 4'hF, 32'h0BAD_F00D);
    for (int a = 0; a < 2; a++) begin
      @(negedge clk); check("restart_ready", bus.DReady, 1'b0); tick();
    end
    do_txn(1'b0, 32'h28, 4'h0, 32'h0, 32'h0, "restart_rd");

    // Back-to-back requests on the cycle after each ready.
    do_txn(1'b1, 32'h14, 4'hF, 32'h5A5A_0014, 32'h0, "b2b_wr");
    do_txn(1'b0, 32'h10, 4'h0, 32'h0, 32'h12AB_5678, "b2b_rd0");
    do_txn(1'b0, 32'h14, 4'h0, 32'h0, 32'h5A5A_0014, "b2b_rd1");
    idle();
    tick();

    // Zero-latency instance: ready and data in the request cycle.
    present0(1'b0, 32'h40, 4'h0, 32'h0);
    @(negedge clk);
    check("l0_rd_ready", bus0.DReady, 1'b1);
    check("l0_rd_data", bus0.DRData, 32'h0);
    tick();
    present0(1'b1, 32'h44, 4'hF, 32'h7766_5544);
    @(negedge clk);
    check("l0_wr_ready", bus0.DReady, 1'b1);
    tick();
    present0(1'b0, 32'h44, 4'h0, 32'h0);
    @(negedge clk);
    check("l0_rd2_ready", bus0.DReady, 1'b1);
    check("l0_rd2_data", bus0.DRData, 32'h7766_5544);
    tick();
    present0(1'b1, 32'h44, 4'b0001, 32'h0000_00EE);
    @(negedge clk);
    check("l0_sb_ready", bus0.DReady, 1'b1);
    tick();
    present0(1'b0, 32'h44, 4'h0, 32'h0);
    @(negedge clk);
    check("l0_rd3_data", bus0.DRData, 32'h7766_55EE);
    tick();
    @(negedge clk);
    check("l0_hold_ready", bus0.DReady, 1'b1);
    check("l0_hold_data", bus0.DRData, 32'h7766_55EE);
    tick();
    bus0.DREn = 1'b0; bus0.DWEn = 1'b0;
    tick();

    // Randomized traffic against the memory model.
    for (int n = 0; n < 300; n++) begin
      bit          wr   = 1'($urandom_range(0, 1));
      logic [31:0] addr = 32'($urandom_range(0, 1023)) << 2;
      logic [3:0]  be   = 4'($urandom_range(0, 15));
      logic [31:0] wd   = $urandom;
      int unsigned mode = $urandom_range(0, 3);
      if (mode >= 2) begin
        int unsigned k = $urandom_range(1, LAT);
        pc += 32'd4;
        present(wr, addr, be, wd);
        for (int unsigned a = 0; a < k; a++) begin
          @(negedge clk); check("rnd_abort_ready", bus.DReady, 1'b0); tick();
        end
        if (mode == 2) begin
          idle();
          @(negedge clk); check("rnd_abort_drop", bus.DReady, 1'b0); tick();
        end
      end else begin
        do_txn(wr, addr, be, wd, mdl[widx(addr)], "rnd");
        for (int unsigned f = $urandom_range(0, 2); f > 0; f--) begin
          bus.DWData = $urandom;
          @(negedge clk); check("rnd_freeze_ready", bus.DReady, 1'b1); tick();
        end
        if ($urandom_range(0, 1) == 1) begin
          idle();
          tick();
        end
      end
    end
    idle();
    tick();

    // Final sweep of every word.
    for (int unsigned w = 0; w < WORDS; w++) begin
      do_txn(1'b0, 32'(w << 2), 4'h0, 32'h0, mdl[w], "sweep");
    end
    idle();
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
